// File: rtl/spi_display_rx.sv
// spi_display_rx
// Display-side receiver for the 4-wire command/data SPI link. The SPI lines are
// oversampled with the system clock, assembled into bytes, and decoded for the
// NOP / MADCTL / COLMOD / RAMWR subset. RAMWR pixel pairs become framebuffer
// write strobes with an auto-incrementing, wrapping address.
//
// Pipeline from the first clock edge that samples the 8th SCK high:
//   SYNC_STAGES synchronizer edges -> edge-detect register -> byte capture -> decoder outputs,
// so strobes and register updates appear SYNC_STAGES+2 edges after that first sample.

module spi_display_rx #(
    parameter int PIXELS      = 76800,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK_50MHz,
    input  logic        RESET_N,
    input  logic        SPI_CS,
    input  logic        SPI_RESET,
    input  logic        SPI_DC,
    input  logic        SPI_SDI,
    input  logic        SPI_SCK,
    output logic [16:0] FB_WA,
    output logic [15:0] FB_WD,
    output logic        FB_WE,
    output logic [7:0]  MADCTL,
    output logic [7:0]  COLMOD,
    output logic        FRAME_DONE,
    output logic        CMD_ERR
);

    localparam logic [16:0] LastAddr = 17'(PIXELS - 1);

    typedef enum logic [2:0] {
        Idle,
        MadctlArg,
        ColmodArg,
        PixHi,
        PixLo
    } state_t;

    // Synchronizer chains; CS and the display reset idle high (inactive)
    logic [SYNC_STAGES-1:0] csSync_q;
    logic [SYNC_STAGES-1:0] rstSync_q;
    logic [SYNC_STAGES-1:0] dcSync_q;
    logic [SYNC_STAGES-1:0] sdiSync_q;
    logic [SYNC_STAGES-1:0] sckSync_q;

    logic csS;
    logic dcS;
    logic sdiS;
    logic sckS;
    logic softRst;

    // Edge-detect stage
    logic sckPrev_q;
    logic rise_q;
    logic sdiDly_q;
    logic dcDly_q;
    logic csDly_q;

    // Byte capture stage
    logic [2:0] bitCnt_q;
    logic [6:0] shift_q;
    logic [7:0] byte_q;
    logic       byteDc_q;
    logic       byteValid_q;
    logic       csCap_q;

    // Decoder state and outputs
    state_t      state_q,     state_d;
    logic [16:0] addr_q,      addr_d;
    logic [7:0]  pixHi_q,     pixHi_d;
    logic [16:0] fbWa_q,      fbWa_d;
    logic [15:0] fbWd_q,      fbWd_d;
    logic        fbWe_q,      fbWe_d;
    logic [7:0]  madctl_q,    madctl_d;
    logic [7:0]  colmod_q,    colmod_d;
    logic        frameDone_q, frameDone_d;
    logic        cmdErr_q,    cmdErr_d;

    assign csS     = csSync_q[SYNC_STAGES-1];
    assign dcS     = dcSync_q[SYNC_STAGES-1];
    assign sdiS    = sdiSync_q[SYNC_STAGES-1];
    assign sckS    = sckSync_q[SYNC_STAGES-1];
    assign softRst = ~rstSync_q[SYNC_STAGES-1];

    // Bring all five SPI lines into the system clock domain
    always_ff @(posedge CLK_50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            csSync_q  <= '1;
            rstSync_q <= '1;
            dcSync_q  <= '0;
            sdiSync_q <= '0;
            sckSync_q <= '0;
        end else begin
            csSync_q  <= {csSync_q[SYNC_STAGES-2:0],  SPI_CS};
            rstSync_q <= {rstSync_q[SYNC_STAGES-2:0], SPI_RESET};
            dcSync_q  <= {dcSync_q[SYNC_STAGES-2:0],  SPI_DC};
            sdiSync_q <= {sdiSync_q[SYNC_STAGES-2:0], SPI_SDI};
            sckSync_q <= {sckSync_q[SYNC_STAGES-2:0], SPI_SCK};
        end
    end

    // Register the SCK rise and keep SDI/DC/CS aligned with it
    always_ff @(posedge CLK_50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            sckPrev_q <= 1'b0;
            rise_q    <= 1'b0;
            sdiDly_q  <= 1'b0;
            dcDly_q   <= 1'b0;
            csDly_q   <= 1'b1;
        end else begin
            sckPrev_q <= sckS;
            rise_q    <= softRst ? 1'b0 : (sckS & ~sckPrev_q);
            sdiDly_q  <= sdiS;
            dcDly_q   <= dcS;
            csDly_q   <= csS;
        end
    end

    // Shift bits MSB-first into a byte; CS high drops any partial byte and wins over a coincident 8th bit
    always_ff @(posedge CLK_50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            bitCnt_q    <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            byteDc_q    <= 1'b0;
            byteValid_q <= 1'b0;
            csCap_q     <= 1'b1;
        end else if (softRst) begin
            bitCnt_q    <= '0;
            shift_q     <= '0;
            byteValid_q <= 1'b0;
            csCap_q     <= csDly_q;
        end else begin
            byteValid_q <= 1'b0;
            csCap_q     <= csDly_q;
            if (csDly_q) begin
                bitCnt_q <= '0;
            end else if (rise_q) begin
                shift_q  <= {shift_q[5:0], sdiDly_q};
                bitCnt_q <= bitCnt_q + 3'd1;
                if (bitCnt_q == 3'd7) begin
                    byteValid_q <= 1'b1;
                    byte_q      <= {shift_q, sdiDly_q};
                    byteDc_q    <= dcDly_q;
                end
            end
        end
    end

    // Decoder state register; the display reset line acts like RESET_N but synchronously
    always_ff @(posedge CLK_50MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= Idle;
            addr_q      <= '0;
            pixHi_q     <= '0;
            fbWa_q      <= '0;
            fbWd_q      <= '0;
            fbWe_q      <= 1'b0;
            madctl_q    <= 8'h00;
            colmod_q    <= 8'h66;
            frameDone_q <= 1'b0;
            cmdErr_q    <= 1'b0;
        end else if (softRst) begin
            state_q     <= Idle;
            addr_q      <= '0;
            pixHi_q     <= '0;
            fbWa_q      <= '0;
            fbWd_q      <= '0;
            fbWe_q      <= 1'b0;
            madctl_q    <= 8'h00;
            colmod_q    <= 8'h66;
            frameDone_q <= 1'b0;
            cmdErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pixHi_q     <= pixHi_d;
            fbWa_q      <= fbWa_d;
            fbWd_q      <= fbWd_d;
            fbWe_q      <= fbWe_d;
            madctl_q    <= madctl_d;
            colmod_q    <= colmod_d;
            frameDone_q <= frameDone_d;
            cmdErr_q    <= cmdErr_d;
        end
    end

    // Command bytes pick the context from any state; data bytes act according to that context
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pixHi_d     = pixHi_q;
        fbWa_d      = fbWa_q;
        fbWd_d      = fbWd_q;
        fbWe_d      = 1'b0;
        madctl_d    = madctl_q;
        colmod_d    = colmod_q;
        frameDone_d = 1'b0;
        cmdErr_d    = 1'b0;

        if (byteValid_q) begin
            if (!byteDc_q) begin
                case (byte_q)
                    8'h00: state_d = Idle;
                    8'h36: state_d = MadctlArg;
                    8'h3A: state_d = ColmodArg;
                    8'h2C: begin
                        state_d = PixHi;
                        addr_d  = '0;
                    end
                    default: begin
                        state_d  = Idle;
                        cmdErr_d = 1'b1;
                    end
                endcase
            end else begin
                case (state_q)
                    MadctlArg: begin
                        madctl_d = byte_q;
                        state_d  = Idle;
                    end
                    ColmodArg: begin
                        colmod_d = byte_q;
                        state_d  = Idle;
                    end
                    PixHi: begin
                        pixHi_d = byte_q;
                        state_d = PixLo;
                    end
                    PixLo: begin
                        fbWd_d  = {pixHi_q, byte_q};
                        fbWa_d  = addr_q;
                        fbWe_d  = 1'b1;
                        state_d = PixHi;
                        if (addr_q == LastAddr) begin
                            addr_d      = '0;
                            frameDone_d = 1'b1;
                        end else begin
                            addr_d = addr_q + 17'd1;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end else if (csCap_q && state_q == PixLo) begin
            state_d = PixHi;
        end
    end

    assign FB_WA      = fbWa_q;
    assign FB_WD      = fbWd_q;
    assign FB_WE      = fbWe_q;
    assign MADCTL     = madctl_q;
    assign COLMOD     = colmod_q;
    assign FRAME_DONE = frameDone_q;
    assign CMD_ERR    = cmdErr_q;

endmodule

// File: tb/tb_spi_display_rx.sv
// tb_spi_display_rx
// Drives SPI byte traffic into spi_display_rx and compares the framebuffer writes,
// configuration registers and error pulses against a byte-level reference model.
// A small PIXELS value keeps the frame-wrap scenario short.

module tb_spi_display_rx;

    localparam int PIXELS      = 20;
    localparam int SYNC_STAGES = 2;
    localparam int LATENCY     = SYNC_STAGES + 2;
    localparam int HALF        = 3;

    localparam int M_IDLE = 0;
    localparam int M_MAD  = 1;
    localparam int M_COL  = 2;
    localparam int M_HI   = 3;
    localparam int M_LO   = 4;

    logic        clk = 1'b0;
    logic        resetN;
    logic        spiCs;
    logic        spiReset;
    logic        spiDc;
    logic        spiSdi;
    logic        spiSck;
    logic [16:0] fbWa;
    logic [15:0] fbWd;
    logic        fbWe;
    logic [7:0]  madctl;
    logic [7:0]  colmod;
    logic        frameDone;
    logic        cmdErr;

    always #10 clk = ~clk;

    spi_display_rx #(
        .PIXELS(PIXELS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK_50MHz(clk),
        .RESET_N(resetN),
        .SPI_CS(spiCs),
        .SPI_RESET(spiReset),
        .SPI_DC(spiDc),
        .SPI_SDI(spiSdi),
        .SPI_SCK(spiSck),
        .FB_WA(fbWa),
        .FB_WD(fbWd),
        .FB_WE(fbWe),
        .MADCTL(madctl),
        .COLMOD(colmod),
        .FRAME_DONE(frameDone),
        .CMD_ERR(cmdErr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int riseCyc = 0;

    // Free-running cycle counter used for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    // Observed framebuffer writes and pulse statistics
    int obsAddr[$];
    int obsData[$];
    bit obsDone[$];
    int obsCyc[$];
    int errCount     = 0;
    int doneCount    = 0;
    int strayDone    = 0;
    int doubleStrobe = 0;
    int lastErrCyc   = -1;
    logic prevWe = 1'b0, prevErr = 1'b0, prevDone = 1'b0;

    // Monitor sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (fbWe === 1'b1) begin
            obsAddr.push_back(int'(fbWa));
            obsData.push_back(int'(fbWd));
            obsDone.push_back(frameDone === 1'b1);
            obsCyc.push_back(cyc);
        end
        if (cmdErr === 1'b1) begin
            errCount++;
            lastErrCyc = cyc;
        end
        if (frameDone === 1'b1) begin
            doneCount++;
            if (fbWe !== 1'b1) strayDone++;
        end
        if ((fbWe === 1'b1 && prevWe) || (cmdErr === 1'b1 && prevErr) || (frameDone === 1'b1 && prevDone))
            doubleStrobe++;
        prevWe   = (fbWe === 1'b1);
        prevErr  = (cmdErr === 1'b1);
        prevDone = (frameDone === 1'b1);
    end

    // Reference model: byte-level view of the display protocol
    int         mMode = M_IDLE;
    logic [7:0] mMad  = 8'h00;
    logic [7:0] mCol  = 8'h66;
    logic [7:0] mHi   = 8'h00;
    int         mAddr = 0;
    int         mWa   = 0;
    int         mWd   = 0;
    int         mErr  = 0;
    int         expErrCyc = -1;
    int expAddr[$];
    int expData[$];
    bit expDone[$];
    int expCyc[$];
    int nextIdx = 0;

    task automatic modelReset();
        mMode = M_IDLE;
        mMad  = 8'h00;
        mCol  = 8'h66;
        mAddr = 0;
        mWa   = 0;
        mWd   = 0;
    endtask

    task automatic modelByte(input logic dc, input logic [7:0] b);
        if (!dc) begin
            case (b)
                8'h00: mMode = M_IDLE;
                8'h36: mMode = M_MAD;
                8'h3A: mMode = M_COL;
                8'h2C: begin
                    mMode = M_HI;
                    mAddr = 0;
                end
                default: begin
                    mMode = M_IDLE;
                    mErr++;
                    expErrCyc = riseCyc + 1 + LATENCY;
                end
            endcase
        end else begin
            case (mMode)
                M_MAD: begin mMad = b; mMode = M_IDLE; end
                M_COL: begin mCol = b; mMode = M_IDLE; end
                M_HI:  begin mHi = b;  mMode = M_LO;   end
                M_LO: begin
                    mWa = mAddr;
                    mWd = {16'h0, mHi, b};
                    expAddr.push_back(mWa);
                    expData.push_back(mWd);
                    expDone.push_back(mAddr == PIXELS - 1);
                    expCyc.push_back(riseCyc + 1 + LATENCY);
                    mAddr = (mAddr + 1) % PIXELS;
                    mMode = M_HI;
                end
                default: ;
            endcase
        end
    endtask

    task automatic modelCsHigh();
        if (mMode == M_LO) mMode = M_HI;
    endtask

    // Stimulus helpers
    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spiBits(input logic dc, input logic [7:0] b, input int nBits);
        for (int i = 0; i < nBits; i++) begin
            spiSck = 1'b0;
            spiDc  = dc;
            spiSdi = b[7-i];
            waitClk(HALF);
            spiSck  = 1'b1;
            riseCyc = cyc;
            waitClk(HALF);
        end
        spiSck = 1'b0;
    endtask

    task automatic sendByte(input logic dc, input logic [7:0] b, input bit keepCs);
        spiCs = 1'b0;
        waitClk(2);
        spiBits(dc, b, 8);
        waitClk(2);
        modelByte(dc, b);
        if (!keepCs) begin
            spiCs = 1'b1;
            waitClk(3);
            modelCsHigh();
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0; spiCs = 1'b1; spiReset = 1'b1;
        spiSck = 1'b0; spiDc = 1'b0; spiSdi = 1'b0;
        waitClk(4);
        modelReset();
        total++; if (madctl !== mMad) begin bad++; $display("[TB] FAIL reset_madctl: got %h want %h", madctl, mMad); end
        total++; if (colmod !== mCol) begin bad++; $display("[TB] FAIL reset_colmod: got %h want %h", colmod, mCol); end
        total++; if (fbWe !== 1'b0) begin bad++; $display("[TB] FAIL reset_fbwe: got %b want 0", fbWe); end
        total++; if (int'(fbWa) !== mWa) begin bad++; $display("[TB] FAIL reset_fbwa: got %0d want %0d", fbWa, mWa); end
        total++; if (int'(fbWd) !== mWd) begin bad++; $display("[TB] FAIL reset_fbwd: got %h want %h", fbWd, mWd); end
        total++; if (frameDone !== 1'b0 || cmdErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulses: got done=%b err=%b want 0/0", frameDone, cmdErr); end
        resetN = 1'b1;
        waitClk(3);
        sendByte(1'b1, 8'h12, 1'b0);
        waitClk(8);
        total++; if (obsAddr.size() != expAddr.size()) begin bad++; $display("[TB] FAIL reset_data_ignored: got %0d writes want %0d", obsAddr.size(), expAddr.size()); end
        total++; if (madctl !== mMad || colmod !== mCol) begin bad++; $display("[TB] FAIL reset_regs_kept: got %h/%h want %h/%h", madctl, colmod, mMad, mCol); end
    endtask

    task automatic test_config();
        sendByte(1'b0, 8'h36, 1'b0);
        sendByte(1'b1, 8'h20, 1'b0);
        sendByte(1'b0, 8'h3A, 1'b0);
        sendByte(1'b1, 8'h55, 1'b0);
        waitClk(8);
        total++; if (madctl !== mMad) begin bad++; $display("[TB] FAIL config_madctl: got %h want %h", madctl, mMad); end
        total++; if (colmod !== mCol) begin bad++; $display("[TB] FAIL config_colmod: got %h want %h", colmod, mCol); end
        total++; if (obsAddr.size() != expAddr.size()) begin bad++; $display("[TB] FAIL config_no_write: got %0d writes want %0d", obsAddr.size(), expAddr.size()); end
        total++; if (errCount != mErr) begin bad++; $display("[TB] FAIL config_no_err: got %0d errors want %0d", errCount, mErr); end
    endtask

    task automatic test_pixels();
        sendByte(1'b0, 8'h2C, 1'b1);
        sendByte(1'b1, 8'hF8, 1'b1);
        sendByte(1'b1, 8'h00, 1'b1);
        sendByte(1'b1, 8'h07, 1'b1);
        sendByte(1'b1, 8'hE0, 1'b0);
        waitClk(8);
        total++; if (obsAddr.size() != expAddr.size()) begin bad++; $display("[TB] FAIL pixels_count: got %0d writes want %0d", obsAddr.size(), expAddr.size()); end
        for (int i = nextIdx; i < expAddr.size() && i < obsAddr.size(); i++) begin
            total++;
            if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsDone[i] !== expDone[i] || obsCyc[i] !== expCyc[i]) begin
                bad++;
                $display("[TB] FAIL pixels_write[%0d]: got a=%0d d=%h done=%b cyc=%0d want a=%0d d=%h done=%b cyc=%0d",
                         i, obsAddr[i], obsData[i], obsDone[i], obsCyc[i], expAddr[i], expData[i], expDone[i], expCyc[i]);
            end
        end
        nextIdx = expAddr.size();
        waitClk(10);
        total++; if (int'(fbWa) !== mWa || int'(fbWd) !== mWd) begin bad++; $display("[TB] FAIL pixels_hold: got a=%0d d=%h want a=%0d d=%h", fbWa, fbWd, mWa, mWd); end
    endtask

    task automatic test_frame_wrap();
        int doneBase = doneCount;
        int expDoneN = 0;
        int base = expAddr.size();
        sendByte(1'b0, 8'h2C, 1'b1);
        for (int p = 0; p <= PIXELS; p++) begin
            sendByte(1'b1, 8'($urandom), 1'b1);
            sendByte(1'b1, 8'($urandom), (p % 2) == 0);
        end
        waitClk(8);
        for (int i = base; i < expDone.size(); i++) if (expDone[i]) expDoneN++;
        total++; if (obsAddr.size() != expAddr.size()) begin bad++; $display("[TB] FAIL wrap_count: got %0d writes want %0d", obsAddr.size(), expAddr.size()); end
        for (int i = nextIdx; i < expAddr.size() && i < obsAddr.size(); i++) begin
            total++;
            if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsDone[i] !== expDone[i] || obsCyc[i] !== expCyc[i]) begin
                bad++;
                $display("[TB] FAIL wrap_write[%0d]: got a=%0d d=%h done=%b cyc=%0d want a=%0d d=%h done=%b cyc=%0d",
                         i, obsAddr[i], obsData[i], obsDone[i], obsCyc[i], expAddr[i], expData[i], expDone[i], expCyc[i]);
            end
        end
        nextIdx = expAddr.size();
        total++; if (doneCount - doneBase != expDoneN) begin bad++; $display("[TB] FAIL wrap_frame_done: got %0d pulses want %0d", doneCount - doneBase, expDoneN); end
    endtask

    task automatic test_abort();
        int base = obsAddr.size();
        sendByte(1'b0, 8'h2C, 1'b1);
        sendByte(1'b1, 8'h11, 1'b1);
        sendByte(1'b1, 8'h11, 1'b1);
        sendByte(1'b1, 8'h22, 1'b1);
        spiBits(1'b1, 8'hF0, 5);
        waitClk(2);
        spiCs = 1'b1;
        waitClk(3);
        modelCsHigh();
        sendByte(1'b1, 8'hAB, 1'b1);
        sendByte(1'b1, 8'hCD, 1'b0);
        waitClk(8);
        total++; if (obsAddr.size() - base != expAddr.size() - nextIdx) begin bad++; $display("[TB] FAIL abort_count: got %0d writes want %0d", obsAddr.size() - base, expAddr.size() - nextIdx); end
        for (int i = nextIdx; i < expAddr.size() && i < obsAddr.size(); i++) begin
            total++;
            if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsDone[i] !== expDone[i] || obsCyc[i] !== expCyc[i]) begin
                bad++;
                $display("[TB] FAIL abort_write[%0d]: got a=%0d d=%h done=%b cyc=%0d want a=%0d d=%h done=%b cyc=%0d",
                         i, obsAddr[i], obsData[i], obsDone[i], obsCyc[i], expAddr[i], expData[i], expDone[i], expCyc[i]);
            end
        end
        nextIdx = expAddr.size();
    endtask

    task automatic test_back_to_back();
        spiCs = 1'b0;
        waitClk(2);
        spiBits(1'b0, 8'h2C, 8);
        modelByte(1'b0, 8'h2C);
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            spiBits(1'b1, b, 8);
            modelByte(1'b1, b);
        end
        waitClk(2);
        spiCs = 1'b1;
        waitClk(3);
        modelCsHigh();
        waitClk(8);
        total++; if (obsAddr.size() != expAddr.size()) begin bad++; $display("[TB] FAIL b2b_count: got %0d writes want %0d", obsAddr.size(), expAddr.size()); end
        for (int i = nextIdx; i < expAddr.size() && i < obsAddr.size(); i++) begin
            total++;
            if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsDone[i] !== expDone[i] || obsCyc[i] !== expCyc[i]) begin
                bad++;
                $display("[TB] FAIL b2b_write[%0d]: got a=%0d d=%h done=%b cyc=%0d want a=%0d d=%h done=%b cyc=%0d",
                         i, obsAddr[i], obsData[i], obsDone[i], obsCyc[i], expAddr[i], expData[i], expDone[i], expCyc[i]);
            end
        end
        nextIdx = expAddr.size();
        total++; if (doubleStrobe != 0) begin bad++; $display("[TB] FAIL b2b_single_cycle: got %0d stretched strobes want 0", doubleStrobe); end
        total++; if (strayDone != 0) begin bad++; $display("[TB] FAIL b2b_done_alone: got %0d FRAME_DONE without FB_WE want 0", strayDone); end
    endtask

    task automatic test_error_soft_reset();
        sendByte(1'b0, 8'h99, 1'b0);
        waitClk(8);
        total++; if (errCount != mErr) begin bad++; $display("[TB] FAIL err_count: got %0d want %0d", errCount, mErr); end
        total++; if (lastErrCyc != expErrCyc) begin bad++; $display("[TB] FAIL err_latency: got cyc %0d want %0d", lastErrCyc, expErrCyc); end
        sendByte(1'b1, 8'h44, 1'b0);
        waitClk(8);
        total++; if (obsAddr.size() != expAddr.size() || madctl !== mMad || colmod !== mCol) begin
            bad++; $display("[TB] FAIL err_data_ignored: got %0d writes %h/%h want %0d writes %h/%h", obsAddr.size(), madctl, colmod, expAddr.size(), mMad, mCol);
        end
        sendByte(1'b0, 8'h36, 1'b0);
        sendByte(1'b1, 8'h5C, 1'b0);
        sendByte(1'b0, 8'h2C, 1'b1);
        sendByte(1'b1, 8'h9E, 1'b1);
        spiBits(1'b1, 8'h3C, 3);
        spiReset = 1'b0;
        waitClk(6);
        modelReset();
        spiReset = 1'b1;
        waitClk(6);
        spiCs = 1'b1;
        waitClk(6);
        total++; if (madctl !== mMad || colmod !== mCol) begin bad++; $display("[TB] FAIL soft_reset_regs: got %h/%h want %h/%h", madctl, colmod, mMad, mCol); end
        total++; if (int'(fbWa) !== mWa || int'(fbWd) !== mWd) begin bad++; $display("[TB] FAIL soft_reset_fb: got a=%0d d=%h want a=%0d d=%h", fbWa, fbWd, mWa, mWd); end
        sendByte(1'b1, 8'h77, 1'b0);
        waitClk(8);
        total++; if (obsAddr.size() != expAddr.size()) begin bad++; $display("[TB] FAIL soft_reset_data_ignored: got %0d writes want %0d", obsAddr.size(), expAddr.size()); end
    endtask

    task automatic test_random();
        logic [7:0] cmdTab [5];
        logic [7:0] b;
        int op;
        cmdTab[0] = 8'h00; cmdTab[1] = 8'h36; cmdTab[2] = 8'h3A; cmdTab[3] = 8'h2C; cmdTab[4] = 8'h2C;
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 9);
            if (op <= 1) begin
                b = (op == 0) ? cmdTab[$urandom_range(0, 4)] : 8'($urandom);
                sendByte(1'b0, b, $urandom_range(0, 1) == 1);
            end else if (op == 9) begin
                spiCs = 1'b0;
                waitClk(2);
                spiBits(1'b1, 8'($urandom), $urandom_range(1, 7));
                waitClk(2);
                spiCs = 1'b1;
                waitClk(3);
                modelCsHigh();
            end else begin
                sendByte(1'b1, 8'($urandom), $urandom_range(0, 3) != 0);
            end
        end
        spiCs = 1'b1;
        waitClk(3);
        modelCsHigh();
        waitClk(8);
        total++; if (obsAddr.size() != expAddr.size()) begin bad++; $display("[TB] FAIL random_count: got %0d writes want %0d", obsAddr.size(), expAddr.size()); end
        for (int i = nextIdx; i < expAddr.size() && i < obsAddr.size(); i++) begin
            total++;
            if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsDone[i] !== expDone[i] || obsCyc[i] !== expCyc[i]) begin
                bad++;
                $display("[TB] FAIL random_write[%0d]: got a=%0d d=%h done=%b cyc=%0d want a=%0d d=%h done=%b cyc=%0d",
                         i, obsAddr[i], obsData[i], obsDone[i], obsCyc[i], expAddr[i], expData[i], expDone[i], expCyc[i]);
            end
        end
        nextIdx = expAddr.size();
        total++; if (madctl !== mMad || colmod !== mCol) begin bad++; $display("[TB] FAIL random_regs: got %h/%h want %h/%h", madctl, colmod, mMad, mCol); end
        total++; if (errCount != mErr) begin bad++; $display("[TB] FAIL random_errs: got %0d want %0d", errCount, mErr); end
        total++; if (doubleStrobe != 0 || strayDone != 0) begin bad++; $display("[TB] FAIL random_strobes: got %0d stretched, %0d stray want 0/0", doubleStrobe, strayDone); end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_config();
        test_pixels();
        test_frame_wrap();
        test_abort();
        test_back_to_back();
        test_error_soft_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
